// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-port memory between instruction fetch and data access.
// Data wins ties, with a streak limit so that fetch cannot starve.
module mem_port_arbiter #(
   parameter int unsigned ADDR_W     = 8,
   parameter int unsigned DATA_W     = 32,
   parameter int unsigned MEM_LAT    = 1,
   parameter int unsigned STARVE_MAX = 3
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              if_req,
   input  logic [ADDR_W-1:0] if_addr,
   output logic              if_gnt,
   output logic              if_rvalid,
   output logic [DATA_W-1:0] if_rdata,
   input  logic              dm_req,
   input  logic              dm_we,
   input  logic [ADDR_W-1:0] dm_addr,
   input  logic [DATA_W-1:0] dm_wdata,
   output logic              dm_gnt,
   output logic              dm_rvalid,
   output logic [DATA_W-1:0] dm_rdata,
   output logic              mem_en,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic              stall_if,
   output logic              stall_mem
);

   localparam int unsigned StrW = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);

   typedef enum logic [0:0] {StIdle, StBusy} state_e;

   state_e            state_q, state_d;
   logic              owner_q, owner_d;  // 0: fetch, 1: data
   logic [2:0]        lat_cnt_q, lat_cnt_d;
   logic [StrW-1:0]   streak_q, streak_d;
   logic [DATA_W-1:0] if_rdata_q, dm_rdata_q;

   logic done, issue_ok, starve, rd_gnt;

   always_comb begin
      done     = reset && (state_q == StBusy) && (lat_cnt_q == 3'(MEM_LAT));
      issue_ok = reset && ((state_q == StIdle) || done);
      starve   = (streak_q == StrW'(STARVE_MAX));

      if_gnt = issue_ok && if_req && (!dm_req || starve);
      dm_gnt = issue_ok && dm_req && !(if_req && starve);

      mem_en    = if_gnt || dm_gnt;
      mem_we    = dm_gnt && dm_we;
      mem_addr  = dm_gnt ? dm_addr : if_addr;
      mem_wdata = dm_wdata;

      if_rvalid = done && !owner_q;
      dm_rvalid = done && owner_q;
      if_rdata  = if_rvalid ? mem_rdata : if_rdata_q;
      dm_rdata  = dm_rvalid ? mem_rdata : dm_rdata_q;

      stall_if  = if_req && !if_gnt;
      stall_mem = dm_req && !dm_gnt;
   end

   always_comb begin
      rd_gnt    = if_gnt || (dm_gnt && !dm_we);
      state_d   = state_q;
      owner_d   = owner_q;
      lat_cnt_d = lat_cnt_q;
      streak_d  = streak_q;

      if (!if_req || if_gnt) begin
         streak_d = '0;
      end else if (dm_gnt && !starve) begin
         streak_d = streak_q + StrW'(1);
      end

      // A store issued on a completion cycle leaves nothing outstanding.
      if (rd_gnt) begin
         state_d   = StBusy;
         owner_d   = dm_gnt;
         lat_cnt_d = 3'd1;
      end else if (done) begin
         state_d   = StIdle;
         lat_cnt_d = 3'd0;
      end else if (state_q == StBusy) begin
         lat_cnt_d = lat_cnt_q + 3'd1;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q    <= StIdle;
         owner_q    <= 1'b0;
         lat_cnt_q  <= 3'd0;
         streak_q   <= '0;
         if_rdata_q <= '0;
         dm_rdata_q <= '0;
      end else begin
         state_q    <= state_d;
         owner_q    <= owner_d;
         lat_cnt_q  <= lat_cnt_d;
         streak_q   <= streak_d;
         if_rdata_q <= if_rdata;
         dm_rdata_q <= dm_rdata;
      end
   end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Vector-driven bench for mem_port_arbiter; a second instance with MEM_LAT=3
// covers reset during an outstanding read.
module tb_mem_port_arbiter;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic [31:0] mem [256];

   // MEM_LAT=1 instance
   logic        reset;
   logic        if_req, dm_req, dm_we;
   logic [7:0]  if_addr, dm_addr;
   logic [31:0] dm_wdata;
   logic        if_gnt, if_rvalid, dm_gnt, dm_rvalid, mem_en, mem_we, stall_if, stall_mem;
   logic [31:0] if_rdata, dm_rdata, mem_wdata, mem_rdata;
   logic [7:0]  mem_addr;

   // MEM_LAT=3 instance
   logic        reset3;
   logic        if_req3;
   logic [7:0]  if_addr3;
   logic        if_gnt3, if_rvalid3, dm_gnt3, dm_rvalid3, mem_en3, mem_we3;
   logic        stall_if3, stall_mem3;
   logic [31:0] if_rdata3, dm_rdata3, mem_wdata3, mem_rdata3;
   logic [7:0]  mem_addr3;
   logic [31:0] pipe3 [3];

   mem_port_arbiter #(.ADDR_W(8), .DATA_W(32), .MEM_LAT(1), .STARVE_MAX(3)) u_dut (
      .clk(clk), .reset(reset),
      .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid),
      .if_rdata(if_rdata),
      .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
      .dm_gnt(dm_gnt), .dm_rvalid(dm_rvalid), .dm_rdata(dm_rdata),
      .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata), .stall_if(stall_if), .stall_mem(stall_mem)
   );

   mem_port_arbiter #(.ADDR_W(8), .DATA_W(32), .MEM_LAT(3), .STARVE_MAX(3)) u_dut3 (
      .clk(clk), .reset(reset3),
      .if_req(if_req3), .if_addr(if_addr3), .if_gnt(if_gnt3), .if_rvalid(if_rvalid3),
      .if_rdata(if_rdata3),
      .dm_req(1'b0), .dm_we(1'b0), .dm_addr(8'h00), .dm_wdata(32'h0),
      .dm_gnt(dm_gnt3), .dm_rvalid(dm_rvalid3), .dm_rdata(dm_rdata3),
      .mem_en(mem_en3), .mem_we(mem_we3), .mem_addr(mem_addr3), .mem_wdata(mem_wdata3),
      .mem_rdata(mem_rdata3), .stall_if(stall_if3), .stall_mem(stall_mem3)
   );

   // Memory model: shared array, per-instance read pipelines
   always @(posedge clk) begin
      if (mem_en && mem_we) mem[mem_addr] <= mem_wdata;
      mem_rdata <= mem[mem_addr];
      pipe3[0]  <= mem[mem_addr3];
      pipe3[1]  <= pipe3[0];
      pipe3[2]  <= pipe3[1];
   end
   assign mem_rdata3 = pipe3[2];

   int n_assert = 0;
   int n_fail   = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_assert++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // ctl = {if_gnt, dm_gnt, if_rvalid, dm_rvalid, mem_en, mem_we, stall_if, stall_mem}
   typedef struct {
      logic        ir;
      logic [7:0]  ia;
      logic        dr;
      logic        dw;
      logic [7:0]  da;
      logic [31:0] dd;
      logic [7:0]  ctl;
      logic [7:0]  ea;
      logic [31:0] ird;
      logic [31:0] drd;
   } vec_t;

   function automatic vec_t mk(input logic ir, input logic [7:0] ia, input logic dr,
                               input logic dw, input logic [7:0] da, input logic [31:0] dd,
                               input logic [7:0] ctl, input logic [7:0] ea,
                               input logic [31:0] ird, input logic [31:0] drd);
      vec_t v;
      v.ir = ir; v.ia = ia; v.dr = dr; v.dw = dw; v.da = da; v.dd = dd;
      v.ctl = ctl; v.ea = ea; v.ird = ird; v.drd = drd;
      return v;
   endfunction

   vec_t vecs [20];
   int   lat_seen;
   logic rv_seen;

   initial begin
      for (int i = 0; i < 256; i++) mem[i] = 32'hC0DE_0000 | i;
      for (int i = 0; i < 3; i++) pipe3[i] = 32'h0;
      mem_rdata = 32'h0;

      vecs[0]  = mk(0, 8'h00, 0, 0, 8'h00, 32'h0, 8'b0000_0000, 8'h00, 32'h0, 32'h0);
      vecs[1]  = mk(1, 8'h04, 0, 0, 8'h00, 32'h0, 8'b1000_1000, 8'h04, 32'h0, 32'h0);
      vecs[2]  = mk(0, 8'h00, 0, 0, 8'h00, 32'h0, 8'b0010_0000, 8'h00, 32'hC0DE0004, 32'h0);
      vecs[3]  = mk(1, 8'h08, 1, 0, 8'h10, 32'h0, 8'b0100_1010, 8'h10, 32'hC0DE0004, 32'h0);
      vecs[4]  = mk(1, 8'h08, 0, 0, 8'h10, 32'h0, 8'b1001_1000, 8'h08, 32'hC0DE0004,
                    32'hC0DE0010);
      vecs[5]  = mk(0, 8'h00, 0, 0, 8'h00, 32'h0, 8'b0010_0000, 8'h00, 32'hC0DE0008,
                    32'hC0DE0010);
      vecs[6]  = mk(1, 8'h0C, 1, 0, 8'h11, 32'h0, 8'b0100_1010, 8'h11, 32'hC0DE0008,
                    32'hC0DE0010);
      vecs[7]  = mk(1, 8'h0C, 1, 0, 8'h12, 32'h0, 8'b0101_1010, 8'h12, 32'hC0DE0008,
                    32'hC0DE0011);
      vecs[8]  = mk(1, 8'h0C, 1, 0, 8'h13, 32'h0, 8'b0101_1010, 8'h13, 32'hC0DE0008,
                    32'hC0DE0012);
      vecs[9]  = mk(1, 8'h0C, 1, 0, 8'h14, 32'h0, 8'b1001_1001, 8'h0C, 32'hC0DE0008,
                    32'hC0DE0013);
      vecs[10] = mk(1, 8'h0D, 1, 0, 8'h14, 32'h0, 8'b0110_1010, 8'h14, 32'hC0DE000C,
                    32'hC0DE0013);
      vecs[11] = mk(0, 8'h00, 0, 0, 8'h00, 32'h0, 8'b0001_0000, 8'h00, 32'hC0DE000C,
                    32'hC0DE0014);
      vecs[12] = mk(0, 8'h00, 1, 1, 8'h20, 32'hDEADBEEF, 8'b0100_1100, 8'h20, 32'hC0DE000C,
                    32'hC0DE0014);
      vecs[13] = mk(0, 8'h00, 1, 0, 8'h20, 32'h0, 8'b0100_1000, 8'h20, 32'hC0DE000C,
                    32'hC0DE0014);
      vecs[14] = mk(0, 8'h00, 0, 0, 8'h00, 32'h0, 8'b0001_0000, 8'h00, 32'hC0DE000C,
                    32'hDEADBEEF);
      vecs[15] = mk(1, 8'h05, 0, 0, 8'h00, 32'h0, 8'b1000_1000, 8'h05, 32'hC0DE000C,
                    32'hDEADBEEF);
      vecs[16] = mk(0, 8'h00, 1, 1, 8'h21, 32'h12345678, 8'b0110_1100, 8'h21, 32'hC0DE0005,
                    32'hDEADBEEF);
      vecs[17] = mk(0, 8'h00, 0, 0, 8'h00, 32'h0, 8'b0000_0000, 8'h00, 32'hC0DE0005,
                    32'hDEADBEEF);
      vecs[18] = mk(0, 8'h00, 1, 0, 8'h21, 32'h0, 8'b0100_1000, 8'h21, 32'hC0DE0005,
                    32'hDEADBEEF);
      vecs[19] = mk(0, 8'h00, 0, 0, 8'h00, 32'h0, 8'b0001_0000, 8'h00, 32'hC0DE0005,
                    32'h12345678);

      reset = 1'b0; reset3 = 1'b0;
      if_req = 1'b0; if_addr = 8'h0; dm_req = 1'b0; dm_we = 1'b0; dm_addr = 8'h0;
      dm_wdata = 32'h0; if_req3 = 1'b0; if_addr3 = 8'h0;
      #10;
      reset = 1'b1; reset3 = 1'b1;

      for (int i = 0; i < 20; i++) begin
         @(posedge clk);
         #2;
         if_req = vecs[i].ir; if_addr = vecs[i].ia; dm_req = vecs[i].dr;
         dm_we = vecs[i].dw; dm_addr = vecs[i].da; dm_wdata = vecs[i].dd;
         #2;
         chk($sformatf("vec%0d ctl", i),
             {56'h0, if_gnt, dm_gnt, if_rvalid, dm_rvalid, mem_en, mem_we, stall_if, stall_mem},
             {56'h0, vecs[i].ctl});
         if (vecs[i].ctl[3]) chk($sformatf("vec%0d mem_addr", i), {56'h0, mem_addr},
                                 {56'h0, vecs[i].ea});
         chk($sformatf("vec%0d rdata", i), {if_rdata, dm_rdata}, {vecs[i].ird, vecs[i].drd});
      end
      if_req = 1'b0; dm_req = 1'b0;

      // Reset during an outstanding MEM_LAT=3 read
      @(posedge clk); #2;
      if_req3 = 1'b1; if_addr3 = 8'h30;
      #2;
      chk("lat3 grant", {63'h0, if_gnt3}, 64'h1);
      @(posedge clk); #2;
      if_req3 = 1'b0;
      #2;
      chk("lat3 no early rvalid", {63'h0, if_rvalid3}, 64'h0);
      #1;
      reset3 = 1'b0; if_req3 = 1'b1;
      #1;
      chk("lat3 forced in reset", {60'h0, if_gnt3, if_rvalid3, mem_en3, mem_we3}, 64'h0);
      @(posedge clk); #2;
      chk("lat3 reset state", {if_rdata3, 31'h0, if_gnt3}, 64'h0);
      if_req3 = 1'b0;
      #1;
      reset3 = 1'b1;
      rv_seen = 1'b0;
      for (int k = 0; k < 6; k++) begin
         @(posedge clk); #2;
         if (if_rvalid3 || dm_rvalid3) rv_seen = 1'b1;
      end
      chk("lat3 discarded read", {63'h0, rv_seen}, 64'h0);

      @(posedge clk); #2;
      if_req3 = 1'b1; if_addr3 = 8'h31;
      #2;
      chk("lat3 regrant", {55'h0, if_gnt3, mem_addr3}, {55'h0, 1'b1, 8'h31});
      lat_seen = 0;
      for (int k = 1; k <= 8; k++) begin
         @(posedge clk); #2;
         if_req3 = 1'b0;
         #2;
         if (if_rvalid3 && lat_seen == 0) begin
            lat_seen = k;
            chk("lat3 rdata", {32'h0, if_rdata3}, {32'h0, 32'hC0DE0031});
         end
      end
      chk("lat3 latency", 64'(lat_seen), 64'd3);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
